prog_cntr_stack: RTL
====================

// Module: prog_cntr_stack
// PURPOSE
//  Parametrised program counter with return-address stack (RAS). Successor to the 16-bit PC:
//  adds stall, relative branch, call/return and stack status. Sits in the fetch stage and drives
//  the instruction-memory address. Decode drives the load, branch, call and return commands.
// PARAMETERS
//  WIDTH    16   PC / address width in bits
//  OFF_W    8    signed relative-branch offset width (OFF_W <= WIDTH)
//  INC      1    sequential increment per advance
//  RST_VEC  0    PC value loaded on reset
//  DEPTH    4    RAS entries (power of 2, >= 2)
// PORTS
//  clk     in   1       clock, rising edge
//  rst     in   1       asynchronous reset, active-low
//  en      in   1       advance PC by INC (low = stall)
//  wr      in   1       absolute load: cnt <= dataIn
//  br      in   1       relative branch: cnt <= cnt + sext(brOff)
//  brOff   in   OFF_W   signed branch offset
//  call    in   1       push cnt+INC, then cnt <= dataIn
//  ret     in   1       pop top of stack into cnt
//  dataIn  in   WIDTH   jump/call target
//  cnt     out  WIDTH   current PC (registered)
//  stkFull out  1       RAS holds DEPTH entries
//  stkEmpty out 1       RAS holds 0 entries
//  stkErr  out  1       one-cycle pulse: overflow, underflow or illegal command combination
// BEHAVIOUR
//  - Reset (rst=0, async): cnt=RST_VEC, stack count=0, stkEmpty=1, stkFull=0, stkErr=0.
//  - Every update takes effect at the next rising clk. Commands are sampled at that edge. cnt and all flags are registered.
//  - Priority per cycle: ret > call > wr > br > en > hold. Exactly one action per cycle.
//  - Arithmetic is modulo 2^WIDTH: cnt+INC and cnt+sext(brOff) wrap silently (0xFFFF+1 -> 0x0000).
//  - call with count<DEPTH: push (cnt+INC) mod 2^WIDTH; cnt<=dataIn; count+1.
//  - call when full: push overwrites the oldest entry (circular); count stays DEPTH; cnt<=dataIn; stkErr=1 for 1 cycle.
//  - ret with count>0: cnt<=top; count-1.
//  - ret when empty: cnt holds; count stays 0; stkErr=1 for 1 cycle.
//  - call & ret in the same cycle: ret executes, call ignored; stkErr=1 for 1 cycle (illegal combination).
//  - wr/br/en do not touch the stack. en=0 with no other command: cnt holds (stall).
//  - stkFull/stkEmpty reflect the count after the edge. Both are never 1 together.
//  - Reset mid-operation: immediate return to the reset state; stack contents are discarded (count=0).
// CONFIGURATION
//  Macro PC_ALIGN_CHK_EN:
//  - Defined: any wr/call/ret/br target with bit0=1 (misaligned) is rejected.
//    On rejection: cnt holds, the stack is unchanged (a call does not push, a ret does not pop), stkErr=1 for 1 cycle.
//  - Undefined: no alignment check. All targets are accepted.
// STRUCTURE
//  - Package pc_pkg: pc_cmd_e enum {PC_HOLD, PC_INC, PC_BR, PC_WR, PC_CALL, PC_RET} from the priority decode.
//  - pc_pkg also holds a sext helper and the default constants (WIDTH, DEPTH, RST_VEC).
//  - Sub-module ras_lifo: DEPTH x WIDTH circular LIFO with push/pop/full/empty/ovf/unf and async active-low reset.
//  - Top: command priority decode, next-PC mux, cnt register, stkErr pulse register.
// TESTING (WIDTH=16, DEPTH=4, INC=1, RST_VEC=0)
//  1. Reset release, en=1 for 5 cycles -> cnt 0,1,2,3,4,5. en=0 -> cnt holds at 5. Assert rst mid-run -> cnt=0 immediately.
//  2. cnt=0x0010: wr dataIn=0xFFF0 -> cnt=0xFFF0. Then 16 x en -> cnt=0x0000 (wrap). Then br brOff=8'hFC -> cnt=0xFFFC.
//  3. Four calls from cnt=0x0100 to targets 0x1000/0x2000/0x3000/0x4000 -> stkFull=1.
//     Then four rets -> cnt 0x3001, 0x2001, 0x1001, 0x0101; stkEmpty=1.
//  4. Fifth call when full -> stkErr pulse, oldest entry lost; five rets -> last ret hits empty: cnt holds, stkErr pulse.
//  5. call+ret+wr together with stack top=0x0ABC -> cnt=0x0ABC, stkErr pulse, no push.
//     wr+en together -> wr wins.
//  6. PC_ALIGN_CHK_EN defined: wr dataIn=0x0101 -> cnt unchanged, stkErr pulse.
//     Undefined: same stimulus -> cnt=0x0101, no error.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
// Command encoding, sign-extension helper and default geometry.
package pc_pkg;

    localparam int unsigned PC_WIDTH   = 16;
    localparam int unsigned PC_DEPTH   = 4;
    localparam int unsigned PC_RST_VEC = 0;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_BR,
        PC_WR,
        PC_CALL,
        PC_RET
    } pc_cmd_e;

    // Sign-extend the low w bits of v to 32 bits.
    function automatic logic [31:0] sext(input logic [31:0] v,
                                         input int unsigned w);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << w;
        if (w >= 32) return v;
        return v[w-1] ? (v | mask) : (v & ~mask);
    endfunction

endpackage

// File: rtl/ras_lifo.sv
// Circular return-address LIFO; a push when full overwrites the oldest entry.
// Pop takes precedence over push if both are requested.
module ras_lifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[ptr_q - PW'(1)];
    assign ovf   = push && !pop && full;
    assign unf   = pop && empty;

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (pop) begin
            if (!empty) begin
                ptr_d = ptr_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end else if (push) begin
            // ptr wraps, so the write slot is the oldest entry when full
            mem_d[ptr_q] = din;
            ptr_d        = ptr_q + PW'(1);
            if (!full) cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_cntr_stack.sv
// Program counter with return-address stack for the fetch stage.
// Optional target alignment check: define PC_ALIGN_CHK_EN.
module prog_cntr_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH   = PC_WIDTH,
    parameter int unsigned OFF_W   = 8,
    parameter int unsigned INC     = 1,
    parameter int unsigned RST_VEC = PC_RST_VEC,
    parameter int unsigned DEPTH   = PC_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic             br,
    input  logic [OFF_W-1:0] brOff,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] cnt,
    output logic             stkFull,
    output logic             stkEmpty,
    output logic             stkErr
);

    pc_cmd_e          cmd;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] seq_pc, br_pc, tgt, ras_top;
    logic             mis, push, pop;
    logic             ras_full, ras_empty, ras_ovf, ras_unf;

    assign seq_pc = cnt_q + WIDTH'(INC);
    assign br_pc  = cnt_q + WIDTH'(sext(32'(brOff), OFF_W));

    always_comb begin
        cmd = PC_HOLD;
        priority case (1'b1)
            ret:     cmd = PC_RET;
            call:    cmd = PC_CALL;
            wr:      cmd = PC_WR;
            br:      cmd = PC_BR;
            en:      cmd = PC_INC;
            default: cmd = PC_HOLD;
        endcase
    end

    always_comb begin
        tgt = cnt_q;
        case (cmd)
            PC_RET:  tgt = ras_top;
            PC_CALL: tgt = dataIn;
            PC_WR:   tgt = dataIn;
            PC_BR:   tgt = br_pc;
            PC_INC:  tgt = seq_pc;
            default: tgt = cnt_q;
        endcase
    end

`ifdef PC_ALIGN_CHK_EN
    assign mis = tgt[0] && (cmd inside {PC_WR, PC_CALL, PC_RET, PC_BR});
`else
    assign mis = 1'b0;
`endif

    assign push = (cmd == PC_CALL) && !mis;
    assign pop  = (cmd == PC_RET) && !mis;

    always_comb begin
        cnt_d = tgt;
        if (mis || ((cmd == PC_RET) && ras_empty)) cnt_d = cnt_q;
        err_d = mis || ras_ovf || ras_unf || (call && ret);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= WIDTH'(RST_VEC);
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    ras_lifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ras (
        .clk  (clk),
        .rst_n(rst),
        .push (push),
        .pop  (pop),
        .din  (seq_pc),
        .dout (ras_top),
        .full (ras_full),
        .empty(ras_empty),
        .ovf  (ras_ovf),
        .unf  (ras_unf)
    );

    assign cnt      = cnt_q;
    assign stkFull  = ras_full;
    assign stkEmpty = ras_empty;
    assign stkErr   = err_q;

endmodule
